// File: rtl/upscale_pkg.sv
// rtl/upscale_pkg.sv - shared constants and types for the upsampler line-buffer ring
package upscale_pkg;

    localparam int SLOTS_LOG2  = 3;
    localparam int STRIDE_LOG2 = 11;
    localparam int ADDR_W      = SLOTS_LOG2 + STRIDE_LOG2;
    localparam int PRIME_LINES = 4;
    localparam int ACC_W       = 12;

    // Read base is pulled back by this much so i_hoffset can centre the picture
    localparam logic [ADDR_W-1:0] H_BIAS = ADDR_W'('h80);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

    typedef logic [SLOTS_LOG2-1:0] slot_t;
    typedef logic [SLOTS_LOG2:0]   fill_t;

endpackage

// File: rtl/vscale_accum.sv
// rtl/vscale_accum.sv - Bresenham scale step: advance decision and next accumulator value
module vscale_accum
    import upscale_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         advance,
    output logic [W-1:0] acc_next
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic [W:0] den_x;

    assign den_x = {1'b0, den};
    assign sum   = {1'b0, acc} + {1'b0, num};
    assign diff  = sum - den_x;

    // A zero denominator means "always advance"; a remainder still >= den would need a
    // second advance on the same line, which is not supported, so it collapses to 0.
    always_comb begin
        advance  = (den == '0) || (sum >= den_x);
        acc_next = sum[W-1:0];
        if (advance) begin
            acc_next = (diff >= den_x) ? '0 : diff[W-1:0];
        end
    end

endmodule

// File: rtl/line_slot_scheduler.sv
// rtl/line_slot_scheduler.sv - write/read slot tracking for the 8-slot line-buffer ring
module line_slot_scheduler
    import upscale_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_src_line_done,
    input  logic                    i_src_frame_start,
    input  logic                    i_dst_line_start,
    input  logic                    i_dst_frame_start,
    input  logic [ACC_W-1:0]        i_v_num,
    input  logic [ACC_W-1:0]        i_v_den,
    input  logic [7:0]              i_hoffset,
    output logic [SLOTS_LOG2-1:0]   o_wr_slot,
    output logic [ADDR_W-1:0]       o_wr_base,
    output logic [SLOTS_LOG2-1:0]   o_rd_slot,
    output logic [ADDR_W-1:0]       o_rd_base,
    output logic                    o_rd_valid,
    output logic [SLOTS_LOG2:0]     o_fill,
    output logic                    o_overrun,
    output logic                    o_underrun,
    output logic [1:0]              o_state
);

    localparam fill_t FILL_FULL  = fill_t'(1 << SLOTS_LOG2);
    localparam fill_t FILL_PRIME = fill_t'(PRIME_LINES);
    localparam fill_t FILL_MIN   = fill_t'(2);

    sched_state_t      state_q, state_d;
    slot_t             wr_slot_q, wr_slot_d;
    slot_t             rd_slot_q, rd_slot_d;
    fill_t             fill_q, fill_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic              advance;
    logic [ACC_W-1:0]  acc_step;
    logic              wr_ev;
    logic              rd_ev;
    logic              rd_ok;
    logic              ovr_ev;
    logic              udr_ev;

    vscale_accum #(
        .W(ACC_W)
    ) u_vscale (
        .acc      (acc_q),
        .num      (i_v_num),
        .den      (i_v_den),
        .advance  (advance),
        .acc_next (acc_step)
    );

    assign wr_ev  = i_src_line_done && (state_q != IDLE);
    assign rd_ev  = i_dst_line_start && (state_q == RUN);
    assign ovr_ev = wr_ev && (fill_q == FILL_FULL);
    assign rd_ok  = rd_ev && advance && (fill_q >= FILL_MIN);
    assign udr_ev = rd_ev && advance && (fill_q < FILL_MIN);

    // Next-state: frame start re-primes the ring; otherwise writes, reads and overrun drops
    always_comb begin
        state_d    = state_q;
        wr_slot_d  = wr_slot_q;
        rd_slot_d  = rd_slot_q;
        fill_d     = fill_q;
        acc_d      = acc_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;

        if (i_src_frame_start) begin
            state_d    = PRIME;
            wr_slot_d  = '0;
            rd_slot_d  = '0;
            fill_d     = '0;
            acc_d      = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_ev) begin
                wr_slot_d = wr_slot_q + 1'b1;
            end
            // An overrun drops the oldest line; a coincident read advance shares that move
            if (ovr_ev || rd_ok) begin
                rd_slot_d = rd_slot_q + 1'b1;
            end
            if (!ovr_ev) begin
                if (wr_ev && !rd_ok) begin
                    fill_d = fill_q + 1'b1;
                end else if (!wr_ev && rd_ok) begin
                    fill_d = fill_q - 1'b1;
                end
            end
            if (ovr_ev) begin
                overrun_d = 1'b1;
            end
            if (udr_ev) begin
                underrun_d = 1'b1;
            end
            if (rd_ev) begin
                acc_d = acc_step;
            end
            if (i_dst_frame_start && (state_q == RUN)) begin
                acc_d = '0;
            end
            if ((state_q == PRIME) && (fill_d >= FILL_PRIME)) begin
                state_d    = RUN;
                rd_valid_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            fill_q     <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_slot_q  <= wr_slot_d;
            rd_slot_q  <= rd_slot_d;
            fill_q     <= fill_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_wr_slot  = wr_slot_q;
    assign o_wr_base  = {wr_slot_q, {STRIDE_LOG2{1'b0}}};
    assign o_rd_slot  = rd_slot_q;
    assign o_rd_base  = {rd_slot_q, {STRIDE_LOG2{1'b0}}} - H_BIAS + ADDR_W'(i_hoffset);
    assign o_rd_valid = rd_valid_q;
    assign o_fill     = fill_q;
    assign o_overrun  = overrun_q;
    assign o_underrun = underrun_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_line_slot_scheduler.sv
// tb/tb_line_slot_scheduler.sv - randomized and directed bench for line_slot_scheduler
module tb_line_slot_scheduler;

    logic        clk;
    logic        reset_n;
    logic        i_src_line_done;
    logic        i_src_frame_start;
    logic        i_dst_line_start;
    logic        i_dst_frame_start;
    logic [11:0] i_v_num;
    logic [11:0] i_v_den;
    logic [7:0]  i_hoffset;
    logic [2:0]  o_wr_slot;
    logic [13:0] o_wr_base;
    logic [2:0]  o_rd_slot;
    logic [13:0] o_rd_base;
    logic        o_rd_valid;
    logic [3:0]  o_fill;
    logic        o_overrun;
    logic        o_underrun;
    logic [1:0]  o_state;

    int checks = 0;
    int errors = 0;

    line_slot_scheduler dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_src_line_done   (i_src_line_done),
        .i_src_frame_start (i_src_frame_start),
        .i_dst_line_start  (i_dst_line_start),
        .i_dst_frame_start (i_dst_frame_start),
        .i_v_num           (i_v_num),
        .i_v_den           (i_v_den),
        .i_hoffset         (i_hoffset),
        .o_wr_slot         (o_wr_slot),
        .o_wr_base         (o_wr_base),
        .o_rd_slot         (o_rd_slot),
        .o_rd_base         (o_rd_base),
        .o_rd_valid        (o_rd_valid),
        .o_fill            (o_fill),
        .o_overrun         (o_overrun),
        .o_underrun        (o_underrun),
        .o_state           (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the ring is a queue of buffered source lines; read slot is
    // derived as (write count - lines held) mod 8.
    int m_state = 0;
    int m_wr    = 0;
    int m_acc   = 0;
    int m_valid = 0;
    int m_ovr   = 0;
    int m_udr   = 0;
    int m_line  = 0;
    int m_adv_cnt = 0;
    int m_rep_cnt = 0;
    int ring[$];

    function automatic int m_rd();
        return (m_wr + 8 - ring.size()) % 8;
    endfunction

    function automatic int m_rd_base();
        return ((m_rd() * 2048) - 128 + int'(i_hoffset)) & 'h3fff;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_wr = 0; m_acc = 0; m_valid = 0; m_ovr = 0; m_udr = 0;
            ring.delete();
        end else if (i_src_frame_start) begin
            m_state = 1; m_wr = 0; m_acc = 0; m_valid = 0;
            ring.delete();
        end else if (m_state != 0) begin
            int held;
            int sum;
            bit adv;
            bit pop;
            held = ring.size();
            adv  = 0;
            pop  = 0;
            if (i_dst_line_start && m_state == 2) begin
                sum = m_acc + int'(i_v_num);
                if (i_v_den == 0) begin
                    adv = 1; m_acc = 0;
                end else if (sum >= int'(i_v_den)) begin
                    adv = 1;
                    m_acc = (sum - int'(i_v_den) >= int'(i_v_den)) ? 0 : sum - int'(i_v_den);
                end else begin
                    m_acc = sum;
                end
                if (adv) m_adv_cnt++; else m_rep_cnt++;
                if (adv && held >= 2) pop = 1;
                if (adv && held < 2) m_udr = 1;
            end
            if (i_dst_frame_start && m_state == 2) m_acc = 0;
            if (i_src_line_done) begin
                if (held == 8) begin
                    m_ovr = 1;
                    pop = 1;
                end
                m_wr = (m_wr + 1) % 8;
            end
            if (pop) void'(ring.pop_front());
            if (i_src_line_done) begin
                ring.push_back(m_line);
                m_line++;
            end
            if (m_state == 1 && ring.size() >= 4) begin
                m_state = 2;
                m_valid = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: all outputs against the model
    always @(negedge clk) begin
        chk("state", int'(o_state), m_state);
        chk("wr_slot", int'(o_wr_slot), m_wr);
        chk("wr_base", int'(o_wr_base), m_wr * 2048);
        chk("rd_slot", int'(o_rd_slot), m_rd());
        chk("rd_base", int'(o_rd_base), m_rd_base());
        chk("rd_valid", int'(o_rd_valid), m_valid);
        chk("fill", int'(o_fill), ring.size());
        chk("overrun", int'(o_overrun), m_ovr);
        chk("underrun", int'(o_underrun), m_udr);
    end

    task automatic cyc(input logic sd, input logic sf, input logic dl, input logic df);
        i_src_line_done   = sd;
        i_src_frame_start = sf;
        i_dst_line_start  = dl;
        i_dst_frame_start = df;
        @(posedge clk);
        #1;
        i_src_line_done   = 1'b0;
        i_src_frame_start = 1'b0;
        i_dst_line_start  = 1'b0;
        i_dst_frame_start = 1'b0;
    endtask

    initial begin
        int n_done;
        reset_n = 1'b0;
        i_src_line_done = 0; i_src_frame_start = 0;
        i_dst_line_start = 0; i_dst_frame_start = 0;
        i_v_num = 12'd576; i_v_den = 12'd720; i_hoffset = 8'h10;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_state", int'(o_state), 0);
        chk("reset_rd_base", int'(o_rd_base), 'h3f90);

        // IDLE ignores everything but source frame start
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 0);
        chk("idle_fill", int'(o_fill), 0);

        // 1: prime with four source lines
        cyc(0, 1, 0, 0);
        chk("prime_state", int'(o_state), 1);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
        chk("prime_hold", int'(o_state), 1);
        cyc(1, 0, 0, 0);
        chk("t1_state", int'(o_state), 2);
        chk("t1_wr", int'(o_wr_slot), 4);
        chk("t1_fill", int'(o_fill), 4);
        chk("t1_valid", int'(o_rd_valid), 1);
        chk("t1_rd_base", int'(o_rd_base), 'h3f90);

        // 2: 720 output lines against 576 source lines
        m_adv_cnt = 0; m_rep_cnt = 0; n_done = 0;
        for (int i = 0; i < 720; i++) begin
            cyc(0, 0, 1, 0);
            while (n_done < ((i + 1) * 576) / 720) begin
                cyc(1, 0, 0, 0);
                n_done++;
            end
        end
        chk("t2_adv", m_adv_cnt, 576);
        chk("t2_rep", m_rep_cnt, 144);
        chk("t2_acc", m_acc, 0);
        chk("t2_ovr", int'(o_overrun), 0);
        chk("t2_udr", int'(o_underrun), 0);
        chk("t2_fill", int'(o_fill), 4);

        // 3: fill 2, simultaneous write and advancing read
        i_v_den = 12'd0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t3_fill_pre", int'(o_fill), 2);
        cyc(1, 0, 1, 0);
        chk("t3_rd", int'(o_rd_slot), 3);
        chk("t3_wr", int'(o_wr_slot), 5);
        chk("t3_fill", int'(o_fill), 2);

        // 4: fill to 8, then one more write overruns
        for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0);
        chk("t4_fill_full", int'(o_fill), 8);
        chk("t4_no_ovr", int'(o_overrun), 0);
        cyc(1, 0, 0, 0);
        chk("t4_ovr", int'(o_overrun), 1);
        chk("t4_fill", int'(o_fill), 8);
        chk("t4_rd", int'(o_rd_slot), 4);
        chk("t4_wr", int'(o_wr_slot), 4);

        // 5: drain to 1 then request an advance
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0);
        chk("t5_fill_pre", int'(o_fill), 1);
        cyc(0, 0, 1, 0);
        chk("t5_udr", int'(o_underrun), 1);
        chk("t5_rd", int'(o_rd_slot), 3);
        chk("t5_fill", int'(o_fill), 1);

        // 6: frame start beats a same-cycle write, then async reset mid-PRIME
        cyc(1, 1, 0, 0);
        chk("t6_state", int'(o_state), 1);
        chk("t6_fill", int'(o_fill), 0);
        chk("t6_wr", int'(o_wr_slot), 0);
        chk("t6_valid", int'(o_rd_valid), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_state", int'(o_state), 0);
        chk("t6_rst_fill", int'(o_fill), 0);
        chk("t6_rst_wr_base", int'(o_wr_base), 0);
        chk("t6_rst_ovr", int'(o_overrun), 0);
        chk("t6_rst_udr", int'(o_underrun), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized traffic
        cyc(0, 1, 0, 0);
        for (int c = 0; c < 5000; c++) begin
            if (c % 500 == 0) begin
                int den;
                den = $urandom_range(0, 1000);
                i_v_den = 12'(den);
                i_v_num = 12'($urandom_range(1, den + den / 2 + 1));
                i_hoffset = 8'($urandom);
            end
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 499) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
